// File: rtl/level_controller.sv
// ============================================================================
//  Module      : level_controller
//  Description : Game-level sequencer for Bubble Trouble. Owns the level
//                number, lives counter, level-intro blink gate, spawner
//                reload pulse and the game-over / win flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module level_controller #(
   parameter int MAX_LEVEL    = 12,   // last playable level (1..15)
   parameter int START_LIVES  = 3,    // lives at game start (1..3)
   parameter int INTRO_FRAMES = 120,  // length of the intro/blink phase
   parameter int BLINK_PERIOD = 16,   // frames per blink half-period
   parameter int PAUSE_FRAMES = 90    // freeze after level clear / hit
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       startGame,
   input  logic       allBallsPopped,
   input  logic       playerHit,
   output logic [3:0] levelState,
   output logic       levelVisible,
   output logic       gameActive,
   output logic       loadLevel,
   output logic [1:0] lives,
   output logic       gameOver,
   output logic       gameWon
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [2:0] c_ST_IDLE      = 3'd0;
   localparam logic [2:0] c_ST_INTRO     = 3'd1;
   localparam logic [2:0] c_ST_PLAY      = 3'd2;
   localparam logic [2:0] c_ST_CLEARED   = 3'd3;
   localparam logic [2:0] c_ST_HIT       = 3'd4;
   localparam logic [2:0] c_ST_GAME_OVER = 3'd5;
   localparam logic [2:0] c_ST_WIN       = 3'd6;

   // Terminal counts: a timer of N frames expires while the count is N-1.
   localparam logic [7:0] c_INTRO_LAST   = 8'(INTRO_FRAMES - 1);
   localparam logic [7:0] c_PAUSE_LAST   = 8'(PAUSE_FRAMES - 1);
   localparam logic [7:0] c_BLINK_PERIOD = 8'(BLINK_PERIOD);
   localparam logic [3:0] c_MAX_LEVEL    = 4'(MAX_LEVEL);
   localparam logic [1:0] c_START_LIVES  = 2'(START_LIVES);

   // ------------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------------
   logic [2:0] r_state;
   logic [7:0] r_frame_cnt;

   // ------------------------------------------------------------------------
   // Next-state values; every output is registered from these so a change
   // appears on the same edge that moves the state machine.
   // ------------------------------------------------------------------------
   logic [2:0] w_state_next;
   logic [7:0] w_frame_cnt_next;
   logic [3:0] w_level_next;
   logic [1:0] w_lives_next;
   logic       w_load_next;
   logic       w_visible_next;
   logic [7:0] w_blink_idx;
   logic       w_frame_tick;

   assign w_frame_tick = startOfFrame;

   // Sequencer transitions, frame timer, level and lives bookkeeping
   always_comb begin
      w_state_next     = r_state;
      w_frame_cnt_next = r_frame_cnt;
      w_level_next     = levelState;
      w_lives_next     = lives;
      w_load_next      = 1'b0;

      case (r_state)
         c_ST_IDLE: begin
            if (startGame) begin
               w_state_next     = c_ST_INTRO;
               w_frame_cnt_next = 8'd0;
               w_load_next      = 1'b1;
            end
         end

         c_ST_INTRO: begin
            if (w_frame_tick) begin
               if (r_frame_cnt == c_INTRO_LAST) begin
                  w_state_next     = c_ST_PLAY;
                  w_frame_cnt_next = 8'd0;
               end else begin
                  w_frame_cnt_next = r_frame_cnt + 8'd1;
               end
            end
         end

         c_ST_PLAY: begin
            // A clear takes priority over a simultaneous hit: no life lost.
            if (allBallsPopped) begin
               w_state_next     = c_ST_CLEARED;
               w_frame_cnt_next = 8'd0;
            end else if (playerHit) begin
               w_state_next     = c_ST_HIT;
               w_frame_cnt_next = 8'd0;
               if (lives != 2'd0) begin
                  w_lives_next = lives - 2'd1;
               end
            end
         end

         c_ST_CLEARED: begin
            if (w_frame_tick) begin
               if (r_frame_cnt == c_PAUSE_LAST) begin
                  w_frame_cnt_next = 8'd0;
                  if (levelState >= c_MAX_LEVEL) begin
                     w_state_next = c_ST_WIN;
                  end else begin
                     w_state_next = c_ST_INTRO;
                     w_level_next = levelState + 4'd1;
                     w_load_next  = 1'b1;
                  end
               end else begin
                  w_frame_cnt_next = r_frame_cnt + 8'd1;
               end
            end
         end

         c_ST_HIT: begin
            if (w_frame_tick) begin
               if (r_frame_cnt == c_PAUSE_LAST) begin
                  w_frame_cnt_next = 8'd0;
                  if (lives == 2'd0) begin
                     w_state_next = c_ST_GAME_OVER;
                  end else begin
                     w_state_next = c_ST_INTRO;
                     w_load_next  = 1'b1;
                  end
               end else begin
                  w_frame_cnt_next = r_frame_cnt + 8'd1;
               end
            end
         end

         c_ST_GAME_OVER, c_ST_WIN: begin
            if (startGame) begin
               w_state_next     = c_ST_INTRO;
               w_frame_cnt_next = 8'd0;
               w_level_next     = 4'd1;
               w_lives_next     = c_START_LIVES;
               w_load_next      = 1'b1;
            end
         end

         default: begin
            w_state_next     = c_ST_IDLE;
            w_frame_cnt_next = 8'd0;
         end
      endcase
   end

   // Blink gate: visible while (frame count / half-period) is even
   always_comb begin
      w_blink_idx    = w_frame_cnt_next / c_BLINK_PERIOD;
      w_visible_next = 1'b0;
      case (w_state_next)
         c_ST_IDLE:  w_visible_next = 1'b0;
         c_ST_INTRO: w_visible_next = ~w_blink_idx[0];
         default:    w_visible_next = 1'b1;
      endcase
   end

   // State, timer and all outputs register; asynchronous reset to idle
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state      <= c_ST_IDLE;
         r_frame_cnt  <= 8'd0;
         levelState   <= 4'd1;
         lives        <= c_START_LIVES;
         levelVisible <= 1'b0;
         gameActive   <= 1'b0;
         loadLevel    <= 1'b0;
         gameOver     <= 1'b0;
         gameWon      <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_frame_cnt  <= w_frame_cnt_next;
         levelState   <= w_level_next;
         lives        <= w_lives_next;
         levelVisible <= w_visible_next;
         gameActive   <= (w_state_next == c_ST_PLAY);
         loadLevel    <= w_load_next;
         gameOver     <= (w_state_next == c_ST_GAME_OVER);
         gameWon      <= (w_state_next == c_ST_WIN);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_level_controller.sv
// ============================================================================
//  Module      : tb_level_controller
//  Description : Directed self-checking bench for level_controller using a
//                small parameter set (4-frame intro, 2-frame blink, 3-frame
//                pause, 2 levels, 2 lives); one frame pulse every 10 clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_level_controller;

   logic       clk;
   logic       resetN;
   logic       startOfFrame;
   logic       startGame;
   logic       allBallsPopped;
   logic       playerHit;
   logic [3:0] levelState;
   logic       levelVisible;
   logic       gameActive;
   logic       loadLevel;
   logic [1:0] lives;
   logic       gameOver;
   logic       gameWon;

   int total = 0;
   int bad   = 0;

   level_controller #(
      .MAX_LEVEL    (2),
      .START_LIVES  (2),
      .INTRO_FRAMES (4),
      .BLINK_PERIOD (2),
      .PAUSE_FRAMES (3)
   ) dut (
      .clk            (clk),
      .resetN         (resetN),
      .startOfFrame   (startOfFrame),
      .startGame      (startGame),
      .allBallsPopped (allBallsPopped),
      .playerHit      (playerHit),
      .levelState     (levelState),
      .levelVisible   (levelVisible),
      .gameActive     (gameActive),
      .loadLevel      (loadLevel),
      .lives          (lives),
      .gameOver       (gameOver),
      .gameWon        (gameWon)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle 1 time unit past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Nine idle clocks then a single-clock frame pulse.
   task automatic frame();
      repeat (9) tick();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_game();
      startGame = 1'b1;
      tick();
      startGame = 1'b0;
   endtask

   initial begin
      resetN         = 1'b0;
      startOfFrame   = 1'b0;
      startGame      = 1'b0;
      allBallsPopped = 1'b0;
      playerHit      = 1'b0;
      repeat (3) tick();

      // ---------------- reset values ----------------
      chk("rst_level",   8'(levelState),   8'd1);
      chk("rst_lives",   8'(lives),        8'd2);
      chk("rst_visible", 8'(levelVisible), 8'd0);
      chk("rst_active",  8'(gameActive),   8'd0);
      chk("rst_load",    8'(loadLevel),    8'd0);
      chk("rst_over",    8'(gameOver),     8'd0);
      chk("rst_won",     8'(gameWon),      8'd0);
      resetN = 1'b1;
      frame();
      chk("idle_active", 8'(gameActive),   8'd0);
      chk("idle_vis",    8'(levelVisible), 8'd0);

      // ---------------- 1: start and intro blink ----------------
      pulse_game();
      chk("start_load",  8'(loadLevel),    8'd1);
      chk("start_level", 8'(levelState),   8'd1);
      chk("intro_vis0",  8'(levelVisible), 8'd1);
      chk("intro_act0",  8'(gameActive),   8'd0);
      tick();
      chk("start_load_1clk", 8'(loadLevel), 8'd0);
      frame();
      chk("intro_vis1",  8'(levelVisible), 8'd1);
      frame();
      chk("intro_vis2",  8'(levelVisible), 8'd0);
      frame();
      chk("intro_vis3",  8'(levelVisible), 8'd0);
      chk("intro_act3",  8'(gameActive),   8'd0);
      frame();
      chk("play_active", 8'(gameActive),   8'd1);
      chk("play_vis",    8'(levelVisible), 8'd1);

      // ---------------- 2: clear level 1 and level 2 -> win ----------------
      allBallsPopped = 1'b1;
      tick();
      allBallsPopped = 1'b0;
      chk("clr_active",  8'(gameActive),   8'd0);
      chk("clr_vis",     8'(levelVisible), 8'd1);
      frames(2);
      chk("clr_wait_lvl",  8'(levelState), 8'd1);
      chk("clr_wait_load", 8'(loadLevel),  8'd0);
      frame();
      chk("clr_next_lvl",  8'(levelState), 8'd2);
      chk("clr_next_load", 8'(loadLevel),  8'd1);
      chk("clr_next_vis",  8'(levelVisible), 8'd1);
      tick();
      chk("clr_load_1clk", 8'(loadLevel),  8'd0);
      frames(4);
      chk("l2_play",     8'(gameActive),   8'd1);
      allBallsPopped = 1'b1;
      tick();
      allBallsPopped = 1'b0;
      frames(3);
      chk("win_flag",    8'(gameWon),      8'd1);
      chk("win_level",   8'(levelState),   8'd2);
      chk("win_active",  8'(gameActive),   8'd0);
      chk("win_load",    8'(loadLevel),    8'd0);
      frames(2);
      chk("win_hold",    8'(gameWon),      8'd1);

      // ---------------- 3: lose both lives ----------------
      pulse_game();
      chk("rs_level",    8'(levelState),   8'd1);
      chk("rs_lives",    8'(lives),        8'd2);
      chk("rs_won",      8'(gameWon),      8'd0);
      chk("rs_load",     8'(loadLevel),    8'd1);
      frames(4);
      chk("rs_play",     8'(gameActive),   8'd1);
      playerHit = 1'b1;
      tick();
      playerHit = 1'b0;
      chk("hit1_lives",  8'(lives),        8'd1);
      chk("hit1_active", 8'(gameActive),   8'd0);
      chk("hit1_vis",    8'(levelVisible), 8'd1);
      frames(3);
      chk("hit1_load",   8'(loadLevel),    8'd1);
      chk("hit1_level",  8'(levelState),   8'd1);
      chk("hit1_over",   8'(gameOver),     8'd0);
      frames(4);
      chk("hit1_play",   8'(gameActive),   8'd1);
      playerHit = 1'b1;
      tick();
      playerHit = 1'b0;
      chk("hit2_lives",  8'(lives),        8'd0);
      frames(2);
      chk("hit2_wait",   8'(gameOver),     8'd0);
      frame();
      chk("go_flag",     8'(gameOver),     8'd1);
      chk("go_active",   8'(gameActive),   8'd0);
      chk("go_load",     8'(loadLevel),    8'd0);
      chk("go_lives",    8'(lives),        8'd0);
      pulse_game();
      chk("go_rs_level", 8'(levelState),   8'd1);
      chk("go_rs_lives", 8'(lives),        8'd2);
      chk("go_rs_over",  8'(gameOver),     8'd0);
      chk("go_rs_load",  8'(loadLevel),    8'd1);

      // ---------------- 4: simultaneous hit and clear ----------------
      frames(4);
      chk("both_play",   8'(gameActive),   8'd1);
      playerHit      = 1'b1;
      allBallsPopped = 1'b1;
      tick();
      playerHit      = 1'b0;
      allBallsPopped = 1'b0;
      chk("both_lives",  8'(lives),        8'd2);
      chk("both_active", 8'(gameActive),   8'd0);

      // ---------------- 5: ignored inputs ----------------
      frame();
      playerHit = 1'b1;
      tick();
      playerHit = 1'b0;
      chk("ign_clr_lives", 8'(lives),      8'd2);
      frames(2);
      chk("ign_clr_lvl",   8'(levelState), 8'd2);
      chk("ign_clr_load",  8'(loadLevel),  8'd1);
      playerHit = 1'b1;
      tick();
      playerHit = 1'b0;
      chk("ign_intro_lives",  8'(lives),      8'd2);
      chk("ign_intro_active", 8'(gameActive), 8'd0);
      startGame = 1'b1;
      tick();
      startGame = 1'b0;
      chk("ign_intro_sg_load", 8'(loadLevel), 8'd0);
      frames(4);
      chk("ign_play",    8'(gameActive),   8'd1);
      pulse_game();
      chk("ign_sg_load",   8'(loadLevel),  8'd0);
      chk("ign_sg_level",  8'(levelState), 8'd2);
      chk("ign_sg_lives",  8'(lives),      8'd2);
      chk("ign_sg_active", 8'(gameActive), 8'd1);

      // ---------------- 6: async reset mid-CLEARED ----------------
      allBallsPopped = 1'b1;
      tick();
      allBallsPopped = 1'b0;
      frame();
      chk("pre_rst_level", 8'(levelState), 8'd2);
      resetN = 1'b0;
      #2;
      chk("arst_level",   8'(levelState),   8'd1);
      chk("arst_lives",   8'(lives),        8'd2);
      chk("arst_visible", 8'(levelVisible), 8'd0);
      chk("arst_active",  8'(gameActive),   8'd0);
      chk("arst_won",     8'(gameWon),      8'd0);
      tick();
      resetN = 1'b1;
      frames(4);
      chk("post_rst_active", 8'(gameActive),   8'd0);
      chk("post_rst_vis",    8'(levelVisible), 8'd0);
      chk("post_rst_won",    8'(gameWon),      8'd0);
      chk("post_rst_load",   8'(loadLevel),    8'd0);
      pulse_game();
      chk("post_rst_start",  8'(loadLevel),    8'd1);
      chk("post_rst_vis1",   8'(levelVisible), 8'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
